// File: rtl/adel_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : adel_imem_loader                                                  |
// | Brief  : Byte-stream loader for the 256x16 adel instruction memory.        |
// |          Holds the core in reset until a program load finishes.            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module adel_imem_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [7:0]  pc,
  output logic [15:0] inst,
  output logic        core_nrst,
  output logic        load_done,
  output logic        load_err,
  output logic [8:0]  word_cnt
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LO   = 2'd1;
  localparam logic [1:0] c_ST_HI   = 2'd2;
  localparam logic [1:0] c_ST_RUN  = 2'd3;
  localparam logic [8:0] c_WORDS   = 9'd256;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_lo;
  logic [8:0]  r_word_cnt;
  logic        r_err;
  logic        r_core_nrst;
  logic        r_load_done;
  logic [15:0] r_mem [0:255];

  logic        w_accept;
  logic        w_we;
  logic [15:0] w_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ld_start) begin
      w_state_nxt = c_ST_LO;
    end else begin
      case (r_state)
        c_ST_LO: begin
          if (w_accept) w_state_nxt = ld_last ? c_ST_RUN : c_ST_HI;
        end
        c_ST_HI: begin
          // The 256th word fills memory, so the load ends even without ld_last.
          if (w_accept)
            w_state_nxt = (ld_last || (r_word_cnt == c_WORDS - 9'd1)) ? c_ST_RUN : c_ST_LO;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    ld_ready = (r_state == c_ST_LO) || (r_state == c_ST_HI);
    w_accept = ld_valid && ld_ready && !ld_start && !rst;
    w_we     = w_accept && (r_word_cnt != c_WORDS) &&
               ((r_state == c_ST_HI) || ld_last);
    w_wdata  = (r_state == c_ST_HI) ? {ld_data, r_lo} : {8'h00, ld_data};
    inst     = (r_state == c_ST_RUN) ? r_mem[pc] : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo        <= 8'h00;
      r_word_cnt  <= 9'd0;
      r_err       <= 1'b0;
      r_core_nrst <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_core_nrst <= (w_state_nxt == c_ST_RUN);
      r_load_done <= (w_state_nxt == c_ST_RUN);
      if (ld_start) begin
        r_word_cnt <= 9'd0;
        r_err      <= 1'b0;
      end else if (w_we) begin
        r_word_cnt <= r_word_cnt + 9'd1;
        if (r_state == c_ST_LO) r_err <= 1'b1;
      end
      if (w_accept && (r_state == c_ST_LO)) r_lo <= ld_data;
    end
  end

  // Memory has no reset: contents survive rst and ld_start.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_word_cnt[7:0]] <= w_wdata;
  end

  assign core_nrst = r_core_nrst;
  assign load_done = r_load_done;
  assign load_err  = r_err;
  assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adel_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_adel_imem_loader                                               |
// | Brief  : Directed vector table plus hand-written load sequences.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_adel_imem_loader;

  logic        clk;
  logic        rst;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [7:0]  pc;
  logic [15:0] inst;
  logic        core_nrst;
  logic        load_done;
  logic        load_err;
  logic [8:0]  word_cnt;

  int checks = 0;
  int fails  = 0;

  adel_imem_loader dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .pc(pc),
    .inst(inst), .core_nrst(core_nrst), .load_done(load_done),
    .load_err(load_err), .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic [7:0]  pc;
    logic        rdy;
    logic [15:0] inst;
    logic        nrst;
    logic        done;
    logic        err;
    logic [8:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    ld_valid = 1'b1; ld_data = d; ld_last = l;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
    pc = a;
    #1;
    chk(name, inst, exp);
  endtask

  logic [7:0]  stream [0:19];
  logic [15:0] exp_w;
  logic [8:0]  i9;

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0; pc = 8'h00;
    tick(); tick();
    #1;
    chk("reset.ready", {15'd0, ld_ready}, 16'd0);
    chk("reset.nrst",  {15'd0, core_nrst}, 16'd0);
    chk("reset.done",  {15'd0, load_done}, 16'd0);
    chk("reset.err",   {15'd0, load_err}, 16'd0);
    chk("reset.cnt",   {7'd0, word_cnt}, 16'd0);
    chk("reset.inst",  inst, 16'h0000);
    rst = 1'b0;

    //              st    v     d      l     pc     rdy   inst      nrst  done  err   cnt
    // normal load
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b1, 8'h34, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b0, 8'hEE, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd1});
    tbl.push_back('{1'b0, 1'b1, 8'h78, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd1});
    tbl.push_back('{1'b0, 1'b1, 8'h56, 1'b1, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 16'h5678, 1'b1, 1'b1, 1'b0, 9'd2});
    tbl.push_back('{1'b0, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 9'd2});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 16'h5678, 1'b1, 1'b1, 1'b0, 9'd2});
    // odd length
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 9'd2});
    tbl.push_back('{1'b0, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b1, 8'hBB, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b1, 8'hCC, 1'b1, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 16'h00CC, 1'b1, 1'b1, 1'b1, 9'd2});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'hBBAA, 1'b1, 1'b1, 1'b1, 9'd2});
    // restart coincident with a valid byte
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'hBBAA, 1'b1, 1'b1, 1'b1, 9'd2});
    tbl.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd1});
    tbl.push_back('{1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd1});
    tbl.push_back('{1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b1, 8'h66, 1'b1, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h6655, 1'b1, 1'b1, 1'b0, 9'd1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 16'h00CC, 1'b1, 1'b1, 1'b0, 9'd1});

    foreach (tbl[i]) begin
      ld_start = tbl[i].st; ld_valid = tbl[i].v; ld_data = tbl[i].d;
      ld_last = tbl[i].l; pc = tbl[i].pc;
      #1;
      chk($sformatf("row%0d.ready", i), {15'd0, ld_ready}, {15'd0, tbl[i].rdy});
      chk($sformatf("row%0d.inst", i), inst, tbl[i].inst);
      chk($sformatf("row%0d.nrst", i), {15'd0, core_nrst}, {15'd0, tbl[i].nrst});
      chk($sformatf("row%0d.done", i), {15'd0, load_done}, {15'd0, tbl[i].done});
      chk($sformatf("row%0d.err", i), {15'd0, load_err}, {15'd0, tbl[i].err});
      chk($sformatf("row%0d.cnt", i), {7'd0, word_cnt}, {7'd0, tbl[i].cnt});
      tick();
    end
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; pc = 8'h00;

    // Mid-load reset after 5 bytes; rst coincides with ld_start and a valid byte.
    pulse_start();
    for (int k = 1; k <= 5; k++) send(8'(k), 1'b0);
    rst = 1'b1; ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
    tick();
    rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    #1;
    chk("midrst.ready", {15'd0, ld_ready}, 16'd0);
    chk("midrst.nrst",  {15'd0, core_nrst}, 16'd0);
    chk("midrst.inst",  inst, 16'h0000);
    chk("midrst.cnt",   {7'd0, word_cnt}, 16'd0);
    tick();
    chk("midrst.idle_hold", {15'd0, ld_ready}, 16'd0);
    pulse_start();
    send(8'h77, 1'b1);
    read_chk("midrst.mem1_kept", 8'h01, 16'h0403);
    read_chk("midrst.mem0_new",  8'h00, 16'h0077);
    chk("midrst.err", {15'd0, load_err}, 16'd1);

    // Backpressure: random gaps between bytes, reference stream model.
    for (int k = 0; k < 20; k++) stream[k] = 8'($urandom);
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        ld_valid = 1'b0; ld_data = 8'($urandom); ld_last = 1'($urandom);
        tick();
      end
      send(stream[k], (k == 19));
    end
    chk("bp.cnt",  {7'd0, word_cnt}, 16'd10);
    chk("bp.err",  {15'd0, load_err}, 16'd0);
    chk("bp.done", {15'd0, load_done}, 16'd1);
    for (int w = 0; w < 10; w++) begin
      exp_w = {stream[2*w+1], stream[2*w]};
      read_chk($sformatf("bp.mem%0d", w), 8'(w), exp_w);
    end

    // Full memory: 512 bytes, no ld_last.
    pc = 8'h00;
    pulse_start();
    for (int k = 0; k < 512; k++) begin
      i9 = 9'(k);
      if (k == 511) begin
        #1;
        chk("full.ready_before_last", {15'd0, ld_ready}, 16'd1);
        chk("full.cnt_before_last", {7'd0, word_cnt}, 16'd255);
        chk("full.done_before_last", {15'd0, load_done}, 16'd0);
      end
      send(i9[7:0], 1'b0);
    end
    chk("full.cnt",   {7'd0, word_cnt}, 16'd256);
    chk("full.ready", {15'd0, ld_ready}, 16'd0);
    chk("full.done",  {15'd0, load_done}, 16'd1);
    chk("full.nrst",  {15'd0, core_nrst}, 16'd1);
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b1);
    send(8'hC3, 1'b0);
    chk("full.cnt_sat", {7'd0, word_cnt}, 16'd256);
    chk("full.err",     {15'd0, load_err}, 16'd0);
    read_chk("full.mem255", 8'hFF, 16'hFFFE);
    read_chk("full.mem0",   8'h00, 16'h0100);
    read_chk("full.mem1",   8'h01, 16'h0302);
    read_chk("full.mem128", 8'h80, 16'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
